// File: rtl/ir_cmd_checker.sv
// ir_cmd_checker: validates decoded IR command/complement pairs, tags same-key
// repeats that arrive inside a time window, and queues accepted commands in a
// small show-ahead FIFO read by the sink with valid/ready.
// Build option: define IR_REPEAT_FILTER_EN to drop repeat frames instead of
// queueing them with the repeat tag (cmd_rep then reads 0).
module ir_cmd_checker #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMER_W    = 23,
  parameter int unsigned REPEAT_WIN = 6000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] comando,
  input  logic [7:0] comparador,
  input  logic       frame_vld,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic       cmd_rep,
  output logic [7:0] err_cnt,
  output logic       ovf,
  input  logic       clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CMD_W = 8;
  localparam logic [TIMER_W-1:0] WIN = TIMER_W'(REPEAT_WIN);
  localparam logic [CMD_W-1:0] ERR_MAX = '1;

  typedef struct packed {
    logic             rep;
    logic [CMD_W-1:0] cmd;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  // Repeat tracker state
  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [CMD_W-1:0]     last_key_q, last_key_d;

  // FIFO storage and pointers (index bits plus a wrap bit)
  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;

  // Registered outputs
  logic                 cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]     cmd_data_q, cmd_data_d;
  logic                 cmd_rep_q, cmd_rep_d;
  logic [CMD_W-1:0]     err_cnt_q, err_cnt_d;
  logic                 ovf_q, ovf_d;

  // Per-cycle decisions
  logic                 good_c;
  logic                 bad_c;
  logic                 is_rep_c;
  logic                 push_req_c;
  logic                 empty_c;
  logic                 full_c;
  logic                 pop_c;
  logic                 push_c;
  logic                 drop_c;
  entry_t               new_entry_c;
  entry_t               head_c;

  // Complement check of the incoming frame
  always_comb begin
    good_c = 1'b0;
    bad_c  = 1'b0;
    if (frame_vld) begin
      good_c = (comando == ~comparador);
      bad_c  = ~good_c;
    end
  end

  // Repeat FSM: next state, repeat-window timer and last accepted key
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    last_key_d = last_key_q;
    is_rep_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (good_c) begin
          last_key_d = comando;
          timer_d    = '0;
          state_d    = HELD;
        end
      end
      HELD: begin
        if (good_c) begin
          is_rep_c   = (comando == last_key_q) && (timer_q < WIN);
          last_key_d = comando;
          timer_d    = '0;
        end else if (timer_q == WIN) begin
          // Window expired: forget the key so the next press is fresh
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Entry to queue and whether this frame wants a FIFO slot
  always_comb begin
    new_entry_c.cmd = comando;
`ifdef IR_REPEAT_FILTER_EN
    new_entry_c.rep = 1'b0;
    push_req_c      = good_c && !is_rep_c;
`else
    new_entry_c.rep = is_rep_c;
    push_req_c      = good_c;
`endif
  end

  // FIFO status and push/pop arbitration; a full FIFO only takes a push
  // when the head leaves in the same cycle
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_c   = !empty_c && cmd_ready;
    push_c  = push_req_c && (!full_c || pop_c);
    drop_c  = push_req_c && full_c && !pop_c;
  end

  // FIFO next state and show-ahead head; the head is read from the
  // post-write array so an entry pushed into an empty FIFO shows next cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = new_entry_c;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    head_c      = mem_d[rd_ptr_d[AW-1:0]];
    cmd_valid_d = (wr_ptr_d != rd_ptr_d);
    cmd_data_d  = cmd_valid_d ? head_c.cmd : '0;
`ifdef IR_REPEAT_FILTER_EN
    cmd_rep_d   = 1'b0;
`else
    cmd_rep_d   = cmd_valid_d ? head_c.rep : 1'b0;
`endif
  end

  // Error counter and sticky overflow; clr takes priority over new events
  always_comb begin
    err_cnt_d = err_cnt_q;
    ovf_d     = ovf_q;
    if (bad_c && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + CMD_W'(1);
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end
    if (clr) begin
      err_cnt_d = '0;
      ovf_d     = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      last_key_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      cmd_rep_q   <= 1'b0;
      err_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_key_q  <= last_key_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      cmd_rep_q   <= cmd_rep_d;
      err_cnt_q   <= err_cnt_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_rep   = cmd_rep_q;
  assign err_cnt   = err_cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ir_cmd_checker.sv
// Self-checking bench for ir_cmd_checker: directed scenarios plus randomized
// traffic against a queue-based reference model. The window is shortened so
// expiry scenarios fit in a short run.
module tb_ir_cmd_checker;

  localparam int DEPTH = 4;
  localparam int WIN   = 1500;
`ifdef IR_REPEAT_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] comando = '0;
  logic [7:0] comparador = '0;
  logic       frame_vld = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       clr = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_rep;
  logic [7:0] err_cnt;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [8:0] mq[$];        // {rep, cmd}
  int         m_err = 0;
  bit         m_ovf = 1'b0;
  bit         m_have = 1'b0;
  logic [7:0] m_last = '0;
  int         m_edge = 0;
  int         m_last_edge = 0;

  ir_cmd_checker #(
    .DEPTH(DEPTH),
    .TIMER_W(12),
    .REPEAT_WIN(WIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .comando(comando),
    .comparador(comparador),
    .frame_vld(frame_vld),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_rep(cmd_rep),
    .err_cnt(err_cnt),
    .ovf(ovf),
    .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_err  = 0;
    m_ovf  = 1'b0;
    m_have = 1'b0;
    m_last = '0;
  endtask

  // Drive one cycle, advance the model at the edge, settle 1 time unit after
  task automatic step(input logic fv, input logic [7:0] c, input logic [7:0] p,
                      input logic rdy, input logic cl);
    int  sz0;
    bit  pop;
    bit  rep;
    frame_vld  = fv;
    comando    = c;
    comparador = p;
    cmd_ready  = rdy;
    clr        = cl;
    @(posedge clk);
    m_edge++;
    sz0 = mq.size();
    pop = (sz0 > 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (fv) begin
      if (c == ~p) begin
        rep = m_have && (c == m_last) && ((m_edge - m_last_edge) <= WIN);
        m_have = 1'b1;
        m_last = c;
        m_last_edge = m_edge;
        if (!(FILTER && rep)) begin
          if (sz0 < DEPTH || pop) mq.push_back({rep, c});
          else m_ovf = 1'b1;
        end
      end else if (m_err != 255) begin
        m_err++;
      end
    end
    if (cl) begin
      m_err = 0;
      m_ovf = 1'b0;
    end
    #1;
    frame_vld = 1'b0;
    cmd_ready = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic good(input logic [7:0] k, input logic rdy);
    step(1'b1, k, ~k, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    tests++;
    if (cmd_valid !== 1'b0 || cmd_data !== 8'h00 || cmd_rep !== 1'b0 || err_cnt !== 8'h00 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset: valid=%b data=%h rep=%b err=%0d ovf=%b, want all zero", cmd_valid, cmd_data, cmd_rep, err_cnt, ovf);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 8'h45, 8'hBA, 1'b0, 1'b0);
    tests++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'h45 || cmd_rep !== 1'b0) begin
      fails++;
      $display("FAIL basic_push: valid=%b data=%h rep=%b, want 1 45 0", cmd_valid, cmd_data, cmd_rep);
    end
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tests++;
    if (cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_pop: valid=%b, want 0", cmd_valid);
    end
  endtask

  task automatic test_errors();
    step(1'b1, 8'h45, 8'hBB, 1'b0, 1'b0);
    tests++;
    if (err_cnt !== 8'd1 || cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_one: err=%0d valid=%b, want 1 0", err_cnt, cmd_valid);
    end
    for (int i = 0; i < 300; i++) step(1'b1, 8'h45, 8'hBB, 1'b0, 1'b0);
    tests++;
    if (err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL err_saturate: err=%0d, want 255", err_cnt);
    end
    step(1'b1, 8'h12, 8'h12, 1'b0, 1'b1);
    tests++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL err_clr_wins: err=%0d, want 0", err_cnt);
    end
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tests++;
    if (err_cnt !== 8'd0 || cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_clr: err=%0d valid=%b, want 0 0", err_cnt, cmd_valid);
    end
  endtask

  // Second press of key 16 arrives n cycles after the previous one
  task automatic press_after(input int n, input bit exp_rep, input string name);
    for (int i = 1; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    good(8'h16, 1'b0);
    tests++;
    if (cmd_valid !== !(FILTER && exp_rep) || cmd_rep !== (exp_rep && !FILTER) || (cmd_valid && cmd_data !== 8'h16)) begin
      fails++;
      $display("FAIL %s: valid=%b data=%h rep=%b, want valid=%b data=16 rep=%b", name, cmd_valid, cmd_data, cmd_rep,
               !(FILTER && exp_rep), exp_rep && !FILTER);
    end
  endtask

  task automatic test_repeat();
    drain();
    good(8'h16, 1'b0);
    tests++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'h16 || cmd_rep !== 1'b0) begin
      fails++;
      $display("FAIL rep_first: valid=%b data=%h rep=%b, want 1 16 0", cmd_valid, cmd_data, cmd_rep);
    end
    press_after(1000, 1'b1, "rep_1000");
    press_after(WIN, 1'b1, "rep_at_window");
    press_after(WIN + 1, 1'b0, "rep_past_window");
    press_after(WIN + 10, 1'b0, "rep_expired");
    // Same key twice with a different key in between is not a repeat
    good(8'h17, 1'b1);
    good(8'h16, 1'b1);
    tests++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'h16 || cmd_rep !== 1'b0) begin
      fails++;
      $display("FAIL rep_other_key: valid=%b data=%h rep=%b, want 1 16 0", cmd_valid, cmd_data, cmd_rep);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] k;
    drain();
    for (int i = 0; i < DEPTH; i++) good(8'h30 + 8'(i), 1'b0);
    // Overflow coinciding with clr leaves ovf clear
    step(1'b1, 8'h3A, 8'hC5, 1'b0, 1'b1);
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clr_wins: ovf=%b, want 0", ovf);
    end
    good(8'h3B, 1'b0);
    tests++;
    if (ovf !== 1'b1 || cmd_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: ovf=%b valid=%b, want 1 1", ovf, cmd_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      k = 8'h30 + 8'(i);
      tests++;
      if (cmd_valid !== 1'b1 || cmd_data !== k) begin
        fails++;
        $display("FAIL ovf_drain%0d: valid=%b data=%h, want 1 %h", i, cmd_valid, cmd_data, k);
      end
      step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    tests++;
    if (cmd_valid !== 1'b0 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_empty: valid=%b ovf=%b, want 0 1", cmd_valid, ovf);
    end
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) good(8'h40 + 8'(i), 1'b0);
    good(8'h44, 1'b1);
    tests++;
    if (ovf !== 1'b0 || cmd_valid !== 1'b1 || cmd_data !== 8'h41 || mq.size() != DEPTH) begin
      fails++;
      $display("FAIL push_pop_full: ovf=%b valid=%b data=%h, want 0 1 41", ovf, cmd_valid, cmd_data);
    end
    drain();
  endtask

  task automatic test_random();
    logic [7:0] k;
    logic [7:0] p;
    bit         fv;
    bit         exp_v;
    for (int n = 0; n < 4000; n++) begin
      fv = ($urandom_range(0, 99) < 35);
      case ($urandom_range(0, 3))
        0: k = 8'h16;
        1: k = 8'h45;
        default: k = 8'($urandom_range(0, 7));
      endcase
      p = ($urandom_range(0, 9) < 7) ? ~k : 8'($urandom);
      step(fv, k, p, ($urandom_range(0, 99) < 40), ($urandom_range(0, 199) == 0));
      if ($urandom_range(0, 999) == 0) begin
        for (int i = 0; i < WIN + 5; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      end
      exp_v = (mq.size() > 0);
      tests++;
      if (cmd_valid !== exp_v || err_cnt !== 8'(m_err) || ovf !== m_ovf ||
          (exp_v && (cmd_data !== mq[0][7:0] || cmd_rep !== mq[0][8]))) begin
        fails++;
        $display("FAIL random@%0d: valid=%b data=%h rep=%b err=%0d ovf=%b, want valid=%b head=%h err=%0d ovf=%b",
                 n, cmd_valid, cmd_data, cmd_rep, err_cnt, ovf, exp_v, exp_v ? mq[0] : 9'h0, m_err, m_ovf);
      end
    end
  endtask

  task automatic test_async_reset();
    drain();
    good(8'h21, 1'b0);
    good(8'h22, 1'b0);
    step(1'b1, 8'h05, 8'h05, 1'b0, 1'b0);
    good(8'h16, 1'b0);
    tests++;
    if (cmd_valid !== 1'b1 || mq.size() != 3 || err_cnt === 8'd0) begin
      fails++;
      $display("FAIL areset_setup: valid=%b err=%0d, want 1 nonzero", cmd_valid, err_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (cmd_valid !== 1'b0 || err_cnt !== 8'd0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL areset_async: valid=%b err=%0d ovf=%b, want 0 0 0", cmd_valid, err_cnt, ovf);
    end
    #2 rst_n = 1'b1;
    model_reset();
    good(8'h16, 1'b0);
    tests++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'h16 || cmd_rep !== 1'b0) begin
      fails++;
      $display("FAIL areset_fresh: valid=%b data=%h rep=%b, want 1 16 0", cmd_valid, cmd_data, cmd_rep);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_errors();
    test_repeat();
    test_overflow();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
